multi_link_buffer_controller: RTL

MULTI_LINK_BUFFER_CONTROLLER -- requirements
Module: multi_link_buffer_controller

---
 rtl/multi_link_buffer_controller.sv | 107 ++++++++++
 1 files changed

// File: rtl/multi_link_buffer_controller.sv
// Steers upstream writes round-robin across NUM_LINKS link buffers, either one link or an aligned link pair per write.
// Selection is combinational from ptr/mode/in_full; a width change costs one dead cycle.
module multi_link_buffer_controller #(
  parameter int NUM_LINKS = 4,
  parameter int STALL_W   = 8,
  localparam int LINK_W   = $clog2(NUM_LINKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  input  logic                 multi_width,
  input  logic [NUM_LINKS-1:0] in_full,
  output logic                 wr_ready,
  output logic [LINK_W-1:0]    link_num,
  output logic [NUM_LINKS-1:0] link_mask,
  output logic                 out_full,
  output logic                 wrap,
  output logic [STALL_W-1:0]   stall_cnt
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] SWITCH = 1'b1;

  logic [LINK_W-1:0]    ptr;
  logic                 mode_q;
  logic [0:0]           state;

  logic                 sel_found;
  logic [LINK_W-1:0]    sel_idx;
  logic [NUM_LINKS-1:0] sel_mask;
  logic [LINK_W-1:0]    base;
  logic [LINK_W-1:0]    stride;
  logic [LINK_W-1:0]    next_ptr;
  logic                 accept;

  // Enable mask of the unit starting at idx; in pair mode idx is even so idx|1 is its partner.
  function automatic logic [NUM_LINKS-1:0] unit_mask(input logic [LINK_W-1:0] idx,
                                                     input logic              pair);
    logic [NUM_LINKS-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    if (pair) m[idx | LINK_W'(1)] = 1'b1;
    return m;
  endfunction

  assign base   = ptr & ~LINK_W'(mode_q);
  assign stride = mode_q ? LINK_W'(2) : LINK_W'(1);

  // Index arithmetic wraps at 2^LINK_W == NUM_LINKS, giving the modulo search for free.
  always_comb begin
    logic [LINK_W-1:0]    cand;
    logic [NUM_LINKS-1:0] cmask;
    sel_found = 1'b0;
    sel_idx   = ptr;
    sel_mask  = unit_mask(ptr, mode_q);
    cand      = '0;
    cmask     = '0;
    for (int k = 0; k < NUM_LINKS; k++) begin
      cand  = mode_q ? base + LINK_W'(2 * k) : base + LINK_W'(k);
      cmask = unit_mask(cand, mode_q);
      if (!sel_found && (!mode_q || k < NUM_LINKS / 2) && ((cmask & in_full) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = cand;
        sel_mask  = cmask;
      end
    end
  end

  assign link_num  = sel_idx;
  assign link_mask = sel_mask;
  assign out_full  = ~sel_found;
  assign wr_ready  = (state == RUN) && sel_found && !rst;
  assign accept    = wr_valid && wr_ready;
  assign next_ptr  = sel_idx + stride;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      mode_q    <= 1'b0;
      state     <= RUN;
      stall_cnt <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= accept && (next_ptr <= sel_idx);

      if (wr_valid && !wr_ready) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + STALL_W'(1);
      end else begin
        stall_cnt <= '0;
      end

      case (state)
        RUN: begin
          // An accept racing a mode change still uses the old stride.
          if (accept) ptr <= next_ptr;
          if (multi_width != mode_q) state <= SWITCH;
        end
        default: begin
          mode_q <= multi_width;
          if (multi_width) ptr <= ptr & ~LINK_W'(1);
          state <= RUN;
        end
      endcase
    end
  end

endmodule
